// File: rtl/uart_ser_pkg.sv
// Shared types and helpers for the UART word serializer.
package uart_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    WAIT = 2'd3
  } ser_state_t;

  // Width of a byte-count field able to hold 0..nbytes.
  function automatic int ser_len_w(input int nbytes);
    return $clog2(nbytes) + 1;
  endfunction

  // A length of 0, or one larger than the word, means "whole word".
  function automatic int ser_len_norm(input int len, input int nbytes);
    if ((len == 0) || (len > nbytes)) begin
      return nbytes;
    end
    return len;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Small synchronous FIFO holding {length, word} entries for the serializer.
// full/empty are registered so the top can use them directly as status.
module uart_word_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push_i && !full_q;
  assign do_pop    = pop_i && !empty_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers, count and registered status flags; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_word_serializer.sv
// Buffers result words and hands them to the UART one byte at a time,
// pacing each byte on the UART's completion strobe.
//
// state | meaning
// IDLE  | waiting for a buffered word; pops the head word when one is present
// LOAD  | word and length captured in the shift register / rem counter
// EMIT  | registers the next byte onto Output_dato and pulses flat_out
// WAIT  | byte in flight; next_uart either emits the next byte or ends the word
module uart_word_serializer
  import uart_ser_pkg::*;
#(
  parameter  int DATA_W     = 64,
  parameter  int BYTE_W     = 8,
  parameter  int MSB_FIRST  = 0,
  parameter  int FIFO_DEPTH = 2,
  localparam int NBYTES     = DATA_W / BYTE_W,
  localparam int LEN_W      = ser_len_w(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] input_dato,
  input  logic [LEN_W-1:0]  in_len,
  output logic              ready,
  input  logic              next_uart,
  output logic [BYTE_W-1:0] Output_dato,
  output logic              flat_out,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int FIFO_W = DATA_W + LEN_W;

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [BYTE_W-1:0] out_q, out_d;
  logic              flat_q, flat_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [LEN_W-1:0]  head_len;
  logic [BYTE_W-1:0] sel_byte;
  logic [DATA_W-1:0] sr_shifted;

  // ready reflects the fullness before any same-edge pop, so a full FIFO refuses the push.
  assign fifo_push = start && !fifo_full;
  assign head_len  = fifo_rdata[DATA_W +: LEN_W];

  uart_word_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (fifo_push),
    .pop_i     (fifo_pop),
    .wr_data_i ({in_len, input_dato}),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Byte picked from the shift register and the register after removing it.
  always_comb begin
    if (MSB_FIRST != 0) begin
      sel_byte   = sr_q[DATA_W-1 -: BYTE_W];
      sr_shifted = sr_q << BYTE_W;
    end else begin
      sel_byte   = sr_q[BYTE_W-1:0];
      sr_shifted = sr_q >> BYTE_W;
    end
  end

  // Next-state and output logic for the byte sequencer.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    rem_d    = rem_q;
    out_d    = out_q;
    flat_d   = 1'b0;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sr_d     = fifo_rdata[DATA_W-1:0];
          rem_d    = LEN_W'(ser_len_norm(int'(head_len), NBYTES));
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = EMIT;
      end
      EMIT: begin
        out_d   = sel_byte;
        flat_d  = 1'b1;
        sr_d    = sr_shifted;
        rem_d   = rem_q - LEN_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        // A strobe coinciding with flat_out belongs to the previous byte and is ignored.
        if (next_uart && !flat_q) begin
          if (rem_q != '0) begin
            state_d = EMIT;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ovf_d  = start && fifo_full;
    // When a pop happens the FSM leaves IDLE, so !fifo_empty covers the remaining case.
    busy_d = (state_d != IDLE) || fifo_push || !fifo_empty;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      flat_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      flat_q  <= flat_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign ready       = !fifo_full;
  assign Output_dato = out_q;
  assign flat_out    = flat_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_word_serializer.sv
// Scoreboard bench: an LSB-first and an MSB-first serializer share all stimulus;
// expected byte streams are derived from the words with plain arithmetic.
module tb_uart_word_serializer;

  localparam int DATA_W = 64;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] input_dato = '0;
  logic [LEN_W-1:0]  in_len = '0;
  logic              nu_resp = 1'b0;
  logic              nu_spur = 1'b0;
  logic              nu_idle = 1'b0;
  logic              nu_man = 1'b0;
  logic              next_uart;

  logic       ready_l, flat_l, busy_l, done_l, ovf_l;
  logic [7:0] out_l;
  logic       ready_m, flat_m, busy_m, done_m, ovf_m;
  logic [7:0] out_m;

  assign next_uart = nu_resp | nu_spur | nu_idle | nu_man;

  uart_word_serializer #(.DATA_W(64), .BYTE_W(8), .MSB_FIRST(0), .FIFO_DEPTH(2)) dut_lsb (
    .clk(clk), .rst(rst), .start(start), .input_dato(input_dato), .in_len(in_len),
    .ready(ready_l), .next_uart(next_uart), .Output_dato(out_l), .flat_out(flat_l),
    .busy(busy_l), .done(done_l), .overflow(ovf_l)
  );

  uart_word_serializer #(.DATA_W(64), .BYTE_W(8), .MSB_FIRST(1), .FIFO_DEPTH(2)) dut_msb (
    .clk(clk), .rst(rst), .start(start), .input_dato(input_dato), .in_len(in_len),
    .ready(ready_m), .next_uart(next_uart), .Output_dato(out_m), .flat_out(flat_m),
    .busy(busy_m), .done(done_m), .overflow(ovf_m)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         ovf_cnt_l = 0;
  int         ovf_cnt_m = 0;
  logic [8:0] expq_l[$];
  logic [8:0] expq_m[$];
  bit         resp_en = 1'b0;
  bit         rand_mode = 1'b0;
  bit         spur_en = 1'b0;

  localparam logic [8:0] DONE_MARK = 9'h100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual %0h required nothing at %0t", name, act, $time);
  endtask

  // Reference: first n bytes counted from the chosen end of the word, then a done marker.
  task automatic model(input logic [63:0] w, input logic [3:0] len);
    int n;
    logic [63:0] t;
    n = ((len == 4'd0) || (len > 4'd8)) ? 8 : int'(len);
    for (int i = 0; i < n; i++) begin
      t = w >> (8 * i);
      expq_l.push_back({1'b0, t[7:0]});
      t = w >> (8 * (7 - i));
      expq_m.push_back({1'b0, t[7:0]});
    end
    expq_l.push_back(DONE_MARK);
    expq_m.push_back(DONE_MARK);
  endtask

  task automatic push(input logic [63:0] w, input logic [3:0] len);
    int budget = 2000;
    while (ready_l !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) unexpected("ready_timeout", 64'(ready_l));
    start = 1'b1;
    input_dato = w;
    in_len = len;
    model(w, len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 20000;
    while ((expq_l.size() != 0 || expq_m.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) unexpected("drain_timeout", 64'(expq_l.size() + expq_m.size()));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_flat();
    int budget = 200;
    do begin
      @(negedge clk);
      budget--;
    end while (flat_l !== 1'b1 && budget > 0);
    if (flat_l !== 1'b1) unexpected("flat_timeout", 64'(flat_l));
  endtask

  task automatic wait_done();
    int budget = 2000;
    do begin
      @(negedge clk);
      budget--;
    end while (done_l !== 1'b1 && budget > 0);
    if (done_l !== 1'b1) unexpected("done_timeout", 64'(done_l));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_l"}, {out_l, flat_l, done_l, ovf_l, busy_l, ready_l}, {8'h00, 5'b00001});
    chk({name, "_m"}, {out_m, flat_m, done_m, ovf_m, busy_m, ready_m}, {8'h00, 5'b00001});
  endtask

  // Monitors: every byte and done pulse must match the head of the expected stream.
  always @(negedge clk) begin
    logic [8:0] e;
    if (flat_l === 1'b1) begin
      if (expq_l.size() == 0) unexpected("lsb_extra_byte", 64'(out_l));
      else begin e = expq_l.pop_front(); chk("lsb_byte", 64'({1'b0, out_l}), 64'(e)); end
    end
    if (done_l === 1'b1) begin
      if (expq_l.size() == 0) unexpected("lsb_extra_done", 64'(done_l));
      else begin e = expq_l.pop_front(); chk("lsb_done", 64'(DONE_MARK), 64'(e)); end
    end
    if (ovf_l === 1'b1) ovf_cnt_l++;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (flat_m === 1'b1) begin
      if (expq_m.size() == 0) unexpected("msb_extra_byte", 64'(out_m));
      else begin e = expq_m.pop_front(); chk("msb_byte", 64'({1'b0, out_m}), 64'(e)); end
    end
    if (done_m === 1'b1) begin
      if (expq_m.size() == 0) unexpected("msb_extra_done", 64'(done_m));
      else begin e = expq_m.pop_front(); chk("msb_done", 64'(DONE_MARK), 64'(e)); end
    end
    if (ovf_m === 1'b1) ovf_cnt_m++;
  end

  // UART stand-in: acknowledges each byte after a delay and checks the pacing.
  task automatic respond();
    bit more = 1'b1;
    int d;
    while (more) begin
      d = rand_mode ? int'($urandom_range(1, 4)) : 2;
      if (spur_en && (!rand_mode || $urandom_range(0, 1) == 1)) nu_spur = 1'b1;
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        nu_spur = 1'b0;
        chk("premature_out", 64'({flat_l, done_l, flat_m, done_m}), 64'(0));
      end
      nu_resp = 1'b1;
      @(negedge clk);
      nu_resp = 1'b0;
      if (done_l === 1'b1) begin
        chk("msb_done_sync", 64'(done_m), 64'(1));
        more = 1'b0;
      end else begin
        @(negedge clk);
        chk("byte_latency", 64'({flat_l, flat_m}), 64'(2'b11));
        more = (flat_l === 1'b1);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && flat_l === 1'b1) respond();
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset_values");
    rst = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);

    // Full word, both byte orders, with first-byte latency.
    start = 1'b1;
    input_dato = 64'h0807060504030201;
    in_len = 4'd0;
    model(64'h0807060504030201, 4'd0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_push", 64'({busy_l, busy_m}), 64'(2'b11));
    chk("first_byte_early1", 64'({flat_l, flat_m}), 64'(0));
    @(negedge clk);
    chk("first_byte_early2", 64'({flat_l, flat_m}), 64'(0));
    @(negedge clk);
    chk("first_byte_early3", 64'({flat_l, flat_m}), 64'(0));
    @(negedge clk);
    chk("first_byte_lat", 64'({flat_l, flat_m}), 64'(2'b11));
    wait_idle();

    // Short word: three bytes from the selected end.
    push(64'h0807060504030201, 4'd3);
    wait_idle();

    // next_uart while idle must not produce anything.
    nu_idle = 1'b1;
    @(negedge clk);
    nu_idle = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_no_byte", 64'({flat_l, flat_m, done_l, done_m}), 64'(0));
    end

    // Overflow: four back-to-back pushes into a two-deep FIFO; the fourth is dropped.
    spur_en = 1'b1;
    start = 1'b1;
    input_dato = 64'hA8A7A6A5A4A3A2A1;
    in_len = 4'd0;
    model(64'hA8A7A6A5A4A3A2A1, 4'd0);
    @(negedge clk);
    input_dato = 64'hB8B7B6B5B4B3B2B1;
    in_len = 4'd5;
    model(64'hB8B7B6B5B4B3B2B1, 4'd5);
    @(negedge clk);
    input_dato = 64'hC8C7C6C5C4C3C2C1;
    in_len = 4'd12;
    model(64'hC8C7C6C5C4C3C2C1, 4'd12);
    @(negedge clk);
    chk("ready_when_full", 64'({ready_l, ready_m}), 64'(0));
    chk("no_early_overflow", 64'({ovf_l, ovf_m}), 64'(0));
    input_dato = 64'hD8D7D6D5D4D3D2D1;
    in_len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("overflow_pulse", 64'({ovf_l, ovf_m}), 64'(2'b11));
    @(negedge clk);
    chk("overflow_width", 64'({ovf_l, ovf_m}), 64'(0));
    for (int w = 0; w < 2; w++) begin
      wait_done();
      repeat (2) begin
        @(negedge clk);
        chk("gap_quiet", 64'({flat_l, flat_m}), 64'(0));
      end
      @(negedge clk);
      chk("word_gap", 64'({flat_l, flat_m}), 64'(2'b11));
    end
    wait_idle();
    spur_en = 1'b0;

    // Reset after the third byte: word discarded, no done.
    resp_en = 1'b0;
    push(64'h1122334455667788, 4'd0);
    for (int b = 0; b < 3; b++) begin
      wait_flat();
      if (b < 2) begin
        repeat (2) @(negedge clk);
        nu_man = 1'b1;
        @(negedge clk);
        nu_man = 1'b0;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expq_l.delete();
    expq_m.delete();
    chk_reset_vals("midword_reset");
    repeat (8) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'({flat_l, flat_m, done_l, done_m}), 64'(0));
    end
    resp_en = 1'b1;
    push(64'hAAAAAAAAAAAAAAAA, 4'd0);
    wait_idle();

    // Random words, lengths, gaps and acknowledge delays.
    rand_mode = 1'b1;
    spur_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      push({$urandom, $urandom}, 4'($urandom_range(0, 15)));
    end
    wait_idle();

    chk("final_busy", 64'({busy_l, busy_m}), 64'(0));
    chk("final_ready", 64'({ready_l, ready_m}), 64'(2'b11));
    chk("overflow_count_l", 64'(ovf_cnt_l), 64'(1));
    chk("overflow_count_m", 64'(ovf_cnt_m), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
